// File: rtl/btn_matrix_pkg.sv
// rtl/btn_matrix_pkg.sv - shared constants, event type and key index helper for the button matrix scanner
package btn_matrix_pkg;

    localparam int NUM_X      = 5;
    localparam int NUM_Y      = 4;
    localparam int NUM_KEYS   = 20;
    localparam int KEY_CODE_W = 5;

    typedef struct packed {
        logic                  press;
        logic [KEY_CODE_W-1:0] code;
    } key_evt_t;

    // x*4+y is exactly the concatenation because NUM_Y is 4
    function automatic logic [KEY_CODE_W-1:0] key_idx(input logic [2:0] x, input logic [1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - synchronous show-ahead FIFO of key events with full/empty flags
module btn_evt_fifo
    import btn_matrix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  key_evt_t push_data,
    input  logic     pop,
    output key_evt_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    key_evt_t        mem_q [DEPTH];
    key_evt_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/btn_matrix_scanner.sv
// rtl/btn_matrix_scanner.sv - 5x4 button matrix scanner, per-key debounce and event FIFO
// Define BTN_RELEASE_EVT_EN to also queue release events (key_press=0).
module btn_matrix_scanner
    import btn_matrix_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    inout  wire  [NUM_X-1:0]      BTN_X,
    inout  wire  [NUM_Y-1:0]      BTN_Y,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_press,
    input  logic                  key_ready,
    output logic [NUM_KEYS-1:0]   key_state,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DW = $clog2(SCAN_DIV);
    typedef logic [DW-1:0] dcnt_t;

    localparam dcnt_t      DCNT_LAST = dcnt_t'(SCAN_DIV - 1);
    localparam dcnt_t      SAMPLE_AT = dcnt_t'(SCAN_DIV - 5);
    localparam dcnt_t      UPD_AT    = dcnt_t'(SCAN_DIV - 4);
    localparam logic [2:0] COL_LAST  = 3'(NUM_X - 1);
    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_SCANS - 1);

    dcnt_t                dcnt_q, dcnt_d;
    logic [2:0]           col_q, col_d;
    logic [NUM_X-1:0]     x_drive_q, x_drive_d;
    logic [NUM_Y-1:0]     y_meta_q, y_meta_d;
    logic [NUM_Y-1:0]     y_sync_q, y_sync_d;
    logic [NUM_Y-1:0]     raw_q, raw_d;
    logic [NUM_KEYS-1:0]  key_state_q, key_state_d;
    logic [3:0]           cnt_q [NUM_KEYS];
    logic [3:0]           cnt_d [NUM_KEYS];
    logic                 ovf_q, ovf_d;

    logic                  in_update;
    logic [1:0]            row;
    logic [KEY_CODE_W-1:0] k;
    logic                  new_state;
    logic                  evt_push;
    key_evt_t              evt_data;
    key_evt_t              fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  key_pop;

    // x_drive_q is a registered one-hot so columns hand over without decode glitches
    for (genvar gx = 0; gx < NUM_X; gx++) begin : g_col
        assign BTN_X[gx] = x_drive_q[gx] ? 1'b0 : 1'bz;
    end

    assign in_update = (dcnt_q >= UPD_AT);
    assign row       = dcnt_q[1:0] - UPD_AT[1:0];
    assign k         = key_idx(col_q, row);
    assign key_pop   = key_valid && key_ready;

    always_comb begin
        dcnt_d      = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + 1'b1;
        col_d       = col_q;
        if (dcnt_q == DCNT_LAST) begin
            col_d = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
        end
        x_drive_d        = '0;
        x_drive_d[col_d] = 1'b1;

        y_meta_d = BTN_Y;
        y_sync_d = y_meta_q;
        raw_d    = raw_q;
        if (dcnt_q == SAMPLE_AT) begin
            raw_d = ~y_sync_q;
        end

        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        new_state   = ~key_state_q[k];
        evt_push    = 1'b0;
        evt_data    = '0;
        // one key per cycle, so at most one event is produced per cycle
        if (in_update) begin
            if (raw_q[row] != key_state_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    key_state_d[k] = new_state;
                    cnt_d[k]       = 4'd0;
`ifdef BTN_RELEASE_EVT_EN
                    evt_push       = 1'b1;
                    evt_data.press = new_state;
`else
                    evt_push       = new_state;
                    evt_data.press = 1'b1;
`endif
                    evt_data.code  = k;
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end else begin
                cnt_d[k] = 4'd0;
            end
        end

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (evt_push && fifo_full && !key_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt_q      <= '0;
            col_q       <= 3'd0;
            x_drive_q   <= '0;
            y_meta_q    <= '1;
            y_sync_q    <= '1;
            raw_q       <= '0;
            key_state_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= 4'd0;
            end
            ovf_q       <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            col_q       <= col_d;
            x_drive_q   <= x_drive_d;
            y_meta_q    <= y_meta_d;
            y_sync_q    <= y_sync_d;
            raw_q       <= raw_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    btn_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (evt_push),
        .push_data (evt_data),
        .pop       (key_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_valid = ~fifo_empty;
    assign key_code  = key_valid ? fifo_head.code : '0;
    assign key_press = key_valid ? fifo_head.press : 1'b0;
    assign key_state = key_state_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_matrix_scanner.sv
// tb/tb_btn_matrix_scanner.sv - scoreboard bench for btn_matrix_scanner with a modelled key matrix
module tb_btn_matrix_scanner;
    import btn_matrix_pkg::*;

    localparam int SD   = 16;
    localparam int DEB  = 3;
    localparam int SCAN = 5 * SD;

    logic        clk = 1'b0;
    logic        rstn;
    wire  [4:0]  BTN_X;
    wire  [3:0]  BTN_Y;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_press;
    logic        key_ready;
    logic [19:0] key_state;
    logic        overflow;
    logic        ovf_clr;

    logic [19:0] pressed;
    logic [3:0]  row_val;
    int          cyc;
    int          pop_cnt;
    int          pops_before;
    int          n_pass;
    int          n_total;
    key_evt_t    exp_q [$];
    key_evt_t    e;

    always #5 clk = ~clk;

    btn_matrix_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .BTN_X     (BTN_X),
        .BTN_Y     (BTN_Y),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_press (key_press),
        .key_ready (key_ready),
        .key_state (key_state),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    for (genvar gx = 0; gx < 5; gx++) begin : g_pu
        pullup (BTN_X[gx]);
    end

    always_comb begin
        row_val = 4'hf;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 4; y++) begin
                if (BTN_X[x] == 1'b0 && pressed[x*4+y]) begin
                    row_val[y] = 1'b0;
                end
            end
        end
    end
    assign BTN_Y = row_val;

    always @(posedge clk) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rstn && key_valid && key_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_evt: got code %0d press %0d, required no event", key_code, key_press);
            end else begin
                e = exp_q.pop_front();
                check("evt_code", 32'(key_code), 32'(e.code));
                check("evt_press", 32'(key_press), 32'(e.press));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < SCAN && (cyc % SCAN) != 0; i++) tick(1);
    endtask

    task automatic expect_evt(input logic press, input logic [4:0] code);
        key_evt_t t;
        t.press = press;
        t.code  = code;
        exp_q.push_back(t);
    endtask

    initial begin
        n_pass = 0; n_total = 0; pop_cnt = 0;
        rstn = 1'b0; key_ready = 1'b1; ovf_clr = 1'b0; pressed = '0;

        // reset state
        tick(3);
        check("rst_btn_x", 32'(BTN_X), 32'h1f);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_press", 32'(key_press), 0);
        check("rst_state", 32'(key_state), 0);
        check("rst_ovf", 32'(overflow), 0);

        // column scan order and dwell
        rstn = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick(1);
            if (n == 1 || n == 15) check("scan_col0", 32'(BTN_X), 32'h1e);
            if (n == 16 || n == 31) check("scan_col1", 32'(BTN_X), 32'h1d);
            if (n == 32) check("scan_col2", 32'(BTN_X), 32'h1b);
            if (n == 48) check("scan_col3", 32'(BTN_X), 32'h17);
            if (n == 79) check("scan_col4", 32'(BTN_X), 32'h0f);
            if (n == 80) check("scan_wrap", 32'(BTN_X), 32'h1e);
        end

        // clean press of key 9 (x=2,y=1)
        pops_before = pop_cnt;
        pressed[9] = 1'b1;
        expect_evt(1'b1, 5'd9);
        tick(2 * SCAN);
        check("k9_after2", 32'(key_state[9]), 0);
        tick(SCAN);
        check("k9_after3", 32'(key_state[9]), 1);
        check("k9_pulses", 32'(pop_cnt - pops_before), 1);
        check("k9_valid_low", 32'(key_valid), 0);

        // release of key 9
        pops_before = pop_cnt;
        pressed[9] = 1'b0;
`ifdef BTN_RELEASE_EVT_EN
        expect_evt(1'b0, 5'd9);
`endif
        tick(2 * SCAN);
        check("k9_rel_hold", 32'(key_state[9]), 1);
        tick(SCAN);
        check("k9_rel_state", 32'(key_state[9]), 0);
`ifdef BTN_RELEASE_EVT_EN
        check("k9_rel_evts", 32'(pop_cnt - pops_before), 1);
`else
        check("k9_rel_evts", 32'(pop_cnt - pops_before), 0);
`endif

        // bouncing key never settles
        pops_before = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed[9] = ~pressed[9];
            tick(SCAN);
            check("bounce_state", 32'(key_state[9]), 0);
        end
        check("bounce_evts", 32'(pop_cnt - pops_before), 0);

        // fill FIFO, then overflow
        key_ready = 1'b0;
        pressed[15:12] = 4'hf;
        for (int c = 12; c <= 15; c++) expect_evt(1'b1, 5'(c));
        tick(DEB * SCAN);
        check("fill_state", 32'(key_state[15:12]), 32'hf);
        check("fill_valid", 32'(key_valid), 1);
        check("fill_head", 32'(key_code), 12);
        check("fill_press", 32'(key_press), 1);
        check("fill_ovf", 32'(overflow), 0);
        pressed[0] = 1'b1;
        tick(DEB * SCAN);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_state0", 32'(key_state[0]), 1);
        check("ovf_head", 32'(key_code), 12);
        pops_before = pop_cnt;
        key_ready = 1'b1;
        tick(10);
        check("drain_pops", 32'(pop_cnt - pops_before), 4);
        check("drain_valid", 32'(key_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        align();
        pressed = '0;
`ifdef BTN_RELEASE_EVT_EN
        expect_evt(1'b0, 5'd0);
        for (int c = 12; c <= 15; c++) expect_evt(1'b0, 5'(c));
`endif
        tick(DEB * SCAN);
        check("all_released", 32'(key_state), 0);

        // reset with events pending
        key_ready = 1'b0;
        align();
        pressed[5:4] = 2'b11;
        tick(DEB * SCAN);
        check("pend_valid", 32'(key_valid), 1);
        check("pend_head", 32'(key_code), 4);
        pressed = '0;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(key_valid), 0);
        check("mid_rst_state", 32'(key_state), 0);
        check("mid_rst_btn_x", 32'(BTN_X), 32'h1f);
        tick(2);
        rstn = 1'b1;
        tick(1);
        check("restart_col0", 32'(BTN_X), 32'h1e);
        tick(15);
        check("restart_col1", 32'(BTN_X), 32'h1d);
        key_ready = 1'b1;
        tick(2 * SCAN);
        check("post_rst_valid", 32'(key_valid), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/btn_matrix_scanner.md
# btn_matrix_scanner

Scans the board's 5×4 push-button matrix on `BTN_X`/`BTN_Y` and debounces each of the 20 keys. It delivers key-press events to the game controller through a valid/ready interface backed by a small event FIFO. It is the input-side counterpart of the serial LED/7-segment drivers and sits directly behind the `Game_of_life` top-level pins.

## Interface
- `SCAN_DIV`, 50000: clock cycles per column dwell; minimum 16.
- `DEBOUNCE_SCANS`, 8: consecutive agreeing samples (one per full scan) needed to change a key's stable state; range 1..15.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, minimum 2.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `BTN_X` inout 5: column drive; the selected column is driven 0 and all others are Z.
- `BTN_Y` inout 4: row sense with board pull-ups; the block never drives it (always Z); a pressed key reads 0.
- `key_valid` out 1: FIFO head valid.
- `key_code` out 5: head key index, x*4+y, range 0..19.
- `key_press` out 1: head event type, 1 = press, 0 = release.
- `key_ready` in 1: consumer accepts the head when `key_valid` is also 1.
- `key_state` out 20: debounced level per key, 1 = held.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- `BTN_Y` passes through a 2-flop synchronizer that runs continuously.
- Dwell counter `dcnt` counts 0..SCAN_DIV-1. Column counter `col` counts 0..4 and advances when `dcnt` wraps; after 4 it wraps to 0.
- `BTN_X[col]` is driven 0 for the whole dwell.
- Sample phase: at `dcnt`=SCAN_DIV-5, the inverted synchronized `BTN_Y` is latched into `raw[3:0]`.
- Update phase: at `dcnt`=SCAN_DIV-4+y (y=0..3), row y of key k=col*4+y is processed:
  - If `raw[y]` ≠ `key_state[k]`, `cnt[k]`++. When `cnt[k]` reaches DEBOUNCE_SCANS, `key_state[k]` toggles and `cnt[k]`←0.
  - If `raw[y]` = `key_state[k]`, `cnt[k]`←0.
  - A 0→1 toggle pushes {press=1, code=k}. A 1→0 toggle pushes a release event only when the macro is enabled.
- Serial row processing means at most one push per cycle.
- FIFO is show-ahead: `key_code`/`key_press` present the head whenever `key_valid`=1.
  - Pop happens when `key_valid`&&`key_ready`.
  - Push to a full FIFO without a same-cycle pop is dropped and sets `overflow`.
  - Push with a same-cycle pop while full is accepted.
- When `overflow` is set and `ovf_clr` is asserted in the same cycle, set wins.

## Timing
- Reset values:
  - `BTN_X` all Z; `dcnt`=0, `col`=0.
  - `key_state`=0; all `cnt`=0; FIFO empty.
  - `key_valid`=0, `key_code`=0, `key_press`=0, `overflow`=0.
- The first cycle after `rstn` deasserts drives `BTN_X[0]`=0. Column switching is glitch-free: the old column goes to Z in the same cycle the new one goes to 0.
- Scan period is 5*SCAN_DIV cycles. Settle time before sampling is SCAN_DIV-5 cycles, which includes synchronizer delay.
- Press latency: the event is pushed in the update cycle of the DEBOUNCE_SCANS-th consecutive agreeing sample.
- `key_valid` rises the cycle after a push into an empty FIFO. `key_state` updates in the same cycle as the push.
- Mid-operation reset clears everything immediately, including pending events.

## Configuration
- `BTN_RELEASE_EVT_EN` defined: 1→0 stable transitions push release events with `key_press`=0.
- Undefined: only presses are queued, and `key_press` is the constant 1. `key_state` still tracks releases.

## Structure
- Package `btn_matrix_pkg` holds:
  - `NUM_X`=5, `NUM_Y`=4, `NUM_KEYS`=20, `KEY_CODE_W`=5.
  - Event struct {press, code}.
  - Function `key_idx(x,y)`.
- Sub-module `btn_evt_fifo`: synchronous show-ahead FIFO of the event struct, depth `FIFO_DEPTH`, with full/empty flags.
- The scanner, synchronizer and debounce logic live in the top of the block.

## Test plan
- Reset with `SCAN_DIV`=16 → `BTN_X`=ZZZZZ during reset. After release, `BTN_X[0]`=0 for cycles 0–15, `BTN_X[1]` for 16–31, and so on; `BTN_X[0]` is driven again at cycle 80.
- Hold key x=2,y=1 cleanly with `DEBOUNCE_SCANS`=3 and `key_ready`=1 → after the 3rd sample, `key_state[9]`=1, then a single `key_valid` pulse with `key_code`=9 and `key_press`=1.
- Key 9 toggles every scan for 10 scans → no event, and `key_state[9]` stays 0.
- Keys 12–15 pressed together with `key_ready`=0 → FIFO heads read 12,13,14,15 in order. A later press of key 0 sets `overflow`=1 and is dropped. Then `key_ready`=1 pops exactly 4 events, and `ovf_clr` clears `overflow`.
- Release key 9 after it is stable: with `BTN_RELEASE_EVT_EN` the head is `key_code`=9, `key_press`=0; without the macro no event is queued and `key_state[9]` goes to 0.
- Assert `rstn`=0 with 2 events pending → `key_valid`=0 and `key_state`=0 immediately, and scanning restarts at column 0.
